// File: rtl/hwpe_ctrl_ucode_seq_pkg.sv
// Shared types and constants for the HWPE microcode loop sequencer.
package hwpe_ctrl_package;

   localparam int unsigned UCODE_NB_LOOPS    = 6;
   localparam int unsigned UCODE_NB_REG      = 4;
   localparam int unsigned UCODE_NB_RO_REG   = 28;
   localparam int unsigned UCODE_CNT_WIDTH   = 12;
   localparam int unsigned UCODE_LENGTH      = 16;

   localparam int unsigned UCODE_ADDR_WIDTH  = 5;
   localparam int unsigned UCODE_NBOPS_WIDTH = 5;
   // Wide enough for ucode_addr + nb_ops, so an out-of-range pointer never wraps back into code[].
   localparam int unsigned UCODE_PTR_WIDTH   = 6;
   localparam int unsigned UCODE_LVL_WIDTH   = $clog2(UCODE_NB_LOOPS);
   localparam int unsigned UCODE_ACC_WIDTH   = $clog2(UCODE_NB_LOOPS + 1);

   localparam logic UCODE_OP_ADD = 1'b0;
   localparam logic UCODE_OP_MOV = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      PRESENT,
      UPDATE,
      EXEC,
      FINISHED
   } ucode_seq_state_e;

   typedef logic [UCODE_NB_LOOPS-1:0][UCODE_CNT_WIDTH-1:0] ucode_cnt_vec_t;
   typedef logic [UCODE_NB_REG-1:0][31:0]                  ucode_offs_vec_t;

   typedef struct packed {
      logic                       enable;
      logic                       clear;
      logic [UCODE_ACC_WIDTH-1:0] accum_loop;
   } ctrl_ucode_t;

   typedef struct packed {
      logic       op_sel;
      logic [4:0] a;
      logic [4:0] b;
   } ucode_op_t;

   typedef struct packed {
      logic [UCODE_ADDR_WIDTH-1:0]  ucode_addr;
      logic [UCODE_NBOPS_WIDTH-1:0] nb_ops;
   } ucode_loop_t;

   typedef struct packed {
      ucode_loop_t [UCODE_NB_LOOPS-1:0] loops;
      ucode_op_t   [UCODE_LENGTH-1:0]   code;
      ucode_cnt_vec_t                   range;
   } ucode_t;

   typedef struct packed {
      logic            done;
      logic            valid;
      ucode_offs_vec_t offs;
      ucode_cnt_vec_t  idx;
      logic            accum;
   } flags_ucode_t;

   // A zero range behaves like a single-iteration loop.
   function automatic logic [UCODE_CNT_WIDTH-1:0] ucode_range_max(
      input logic [UCODE_CNT_WIDTH-1:0] rng
   );
      return (rng == '0) ? '0 : rng - UCODE_CNT_WIDTH'(1);
   endfunction

endpackage

// File: rtl/hwpe_ctrl_ucode_seq_nextidx.sv
// Combinational loop-nest stepper: finds the lowest non-saturated loop and
// produces the index vector of the following iteration.
module hwpe_ctrl_ucode_nextidx
   import hwpe_ctrl_package::*;
(
   input  ucode_cnt_vec_t              idx_i,
   input  ucode_cnt_vec_t              range_i,
   output logic [UCODE_LVL_WIDTH-1:0]  level_o,
   output ucode_cnt_vec_t              idx_o,
   output logic                        all_max_o
);

   logic [UCODE_NB_LOOPS-1:0] at_max;
   logic                      found;

   // NOTE: every signal driven here gets a default before any branch, so no latch can be inferred.
   always_comb begin
      at_max  = '0;
      found   = 1'b0;
      level_o = '0;
      for (int i = 0; i < UCODE_NB_LOOPS; i++) begin
         at_max[i] = (idx_i[i] == ucode_range_max(range_i[i]));
         if (!found && !at_max[i]) begin
            found   = 1'b1;
            level_o = UCODE_LVL_WIDTH'(i);
         end
      end
      all_max_o = &at_max;

      idx_o = idx_i;
      if (!all_max_o) begin
         for (int i = 0; i < UCODE_NB_LOOPS; i++) begin
            if (UCODE_LVL_WIDTH'(i) < level_o) begin
               idx_o[i] = '0;
            end else if (UCODE_LVL_WIDTH'(i) == level_o) begin
               idx_o[i] = idx_i[i] + UCODE_CNT_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: rtl/hwpe_ctrl_ucode_seq.sv
// Microcode loop sequencer: walks the loop nest, runs per-loop offset micro-ops
// and presents one iteration (indices + offsets) per valid pulse.
module hwpe_ctrl_ucode_seq
   import hwpe_ctrl_package::*;
#(
   parameter int unsigned NB_LOOPS  = UCODE_NB_LOOPS,
   parameter int unsigned NB_REG    = UCODE_NB_REG,
   parameter int unsigned NB_RO_REG = UCODE_NB_RO_REG,
   parameter int unsigned CNT_WIDTH = UCODE_CNT_WIDTH,
   parameter int unsigned LENGTH    = UCODE_LENGTH
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  ctrl_ucode_t                 ctrl_i,
   input  ucode_t                      ucode_i,
   input  logic [NB_RO_REG-1:0][31:0]  registers_read_i,
   output flags_ucode_t                flags_o
);

   if (NB_LOOPS != UCODE_NB_LOOPS || NB_REG != UCODE_NB_REG || NB_RO_REG != UCODE_NB_RO_REG ||
       CNT_WIDTH != UCODE_CNT_WIDTH || LENGTH != UCODE_LENGTH) begin : g_param_check
      $error("hwpe_ctrl_ucode_seq parameters must match hwpe_ctrl_package constants");
   end
   if (NB_REG + NB_RO_REG != 32) begin : g_regspace_check
      $error("hwpe_ctrl_ucode_seq register space must total 32 entries");
   end

   localparam int unsigned REG_AW  = $clog2(NB_REG);
   localparam int unsigned CODE_AW = $clog2(LENGTH);
   localparam int unsigned PTR_W   = UCODE_PTR_WIDTH;

   ucode_seq_state_e               state_q, state_d;
   ucode_cnt_vec_t                 idx_q, idx_d, out_idx_q, out_idx_d;
   ucode_offs_vec_t                offs_q, offs_d, out_offs_q, out_offs_d;
   logic [PTR_W-1:0]               ptr_q, ptr_d;
   logic [UCODE_NBOPS_WIDTH-1:0]   cnt_q, cnt_d;
   logic                           valid_q, valid_d;
   logic                           done_q, done_d;
   logic                           accum_q, accum_d;

   logic [UCODE_LVL_WIDTH-1:0]     level;
   ucode_cnt_vec_t                 nxt_idx;
   logic                           all_max;
   ucode_loop_t                    loop_sel;
   ucode_op_t                      op;
   logic                           op_in_range;
   logic [31:0]                    opnd_a, opnd_b, op_res;
   logic                           enter_present;

   // Register space: 0..NB_REG-1 are the writable offsets, the rest are read-only operands.
   function automatic logic [31:0] read_reg(
      input logic [4:0]                  sel,
      input ucode_offs_vec_t             offs,
      input logic [NB_RO_REG-1:0][31:0]  ro
   );
      if (sel < 5'(NB_REG)) return offs[sel[REG_AW-1:0]];
      return ro[sel - 5'(NB_REG)];
   endfunction

   function automatic logic accum_of(
      input ucode_cnt_vec_t             idx,
      input logic [UCODE_ACC_WIDTH-1:0] accum_loop
   );
      logic acc;
      acc = 1'b0;
      for (int j = 0; j < NB_LOOPS; j++) begin
         if (j < int'(accum_loop)) acc = acc | (|idx[j]);
      end
      return acc;
   endfunction

   hwpe_ctrl_ucode_nextidx i_nextidx (
      .idx_i     ( idx_q         ),
      .range_i   ( ucode_i.range ),
      .level_o   ( level         ),
      .idx_o     ( nxt_idx       ),
      .all_max_o ( all_max       )
   );

   assign loop_sel    = ucode_i.loops[level];
   assign op_in_range = (ptr_q < PTR_W'(LENGTH));
   assign op          = ucode_i.code[ptr_q[CODE_AW-1:0]];
   assign opnd_a      = read_reg(op.a, offs_q, registers_read_i);
   assign opnd_b      = read_reg(op.b, offs_q, registers_read_i);
   assign op_res      = (op.op_sel == UCODE_OP_MOV) ? opnd_b : opnd_a + opnd_b;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      offs_d        = offs_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      out_idx_d     = out_idx_q;
      out_offs_d    = out_offs_q;
      accum_d       = accum_q;
      valid_d       = 1'b0;
      done_d        = 1'b0;
      enter_present = 1'b0;

      if (ctrl_i.clear) begin
         state_d    = IDLE;
         idx_d      = '0;
         offs_d     = '0;
         ptr_d      = '0;
         cnt_d      = '0;
         out_idx_d  = '0;
         out_offs_d = '0;
         accum_d    = 1'b0;
      end else if (ctrl_i.enable) begin
         case (state_q)
            IDLE: enter_present = 1'b1;
            PRESENT: begin
               if (all_max) begin
                  state_d = FINISHED;
                  done_d  = 1'b1;
               end else begin
                  state_d = UPDATE;
               end
            end
            UPDATE: begin
               idx_d = nxt_idx;
               ptr_d = PTR_W'(loop_sel.ucode_addr);
               cnt_d = loop_sel.nb_ops;
               if (loop_sel.nb_ops != '0) state_d = EXEC;
               else                       enter_present = 1'b1;
            end
            EXEC: begin
               // Out-of-range slots and read-only destinations still consume their cycle.
               if (op_in_range && op.a < 5'(NB_REG)) offs_d[op.a[REG_AW-1:0]] = op_res;
               ptr_d = ptr_q + PTR_W'(1);
               cnt_d = cnt_q - UCODE_NBOPS_WIDTH'(1);
               if (cnt_q <= UCODE_NBOPS_WIDTH'(1)) enter_present = 1'b1;
            end
            default: ;
         endcase

         if (enter_present) begin
            state_d    = PRESENT;
            valid_d    = 1'b1;
            out_idx_d  = idx_d;
            out_offs_d = offs_d;
            accum_d    = accum_of(idx_d, ctrl_i.accum_loop);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         offs_q     <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         out_idx_q  <= '0;
         out_offs_q <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         accum_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         offs_q     <= offs_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         out_idx_q  <= out_idx_d;
         out_offs_q <= out_offs_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         accum_q    <= accum_d;
      end
   end

   assign flags_o.done  = done_q;
   assign flags_o.valid = valid_q;
   assign flags_o.offs  = out_offs_q;
   assign flags_o.idx   = out_idx_q;
   assign flags_o.accum = accum_q;

endmodule

// File: tb/tb_hwpe_ctrl_ucode_seq.sv
// Directed bench for the microcode loop sequencer with a valid-driven scoreboard.
module tb_hwpe_ctrl_ucode_seq;
   import hwpe_ctrl_package::*;

   logic                              clk_i = 1'b0;
   logic                              rst_ni;
   ctrl_ucode_t                       ctrl_i;
   ucode_t                            ucode_i;
   logic [UCODE_NB_RO_REG-1:0][31:0]  registers_read_i;
   flags_ucode_t                      flags_o;

   always #5 clk_i = ~clk_i;

   hwpe_ctrl_ucode_seq dut (
      .clk_i            ( clk_i            ),
      .rst_ni           ( rst_ni           ),
      .ctrl_i           ( ctrl_i           ),
      .ucode_i          ( ucode_i          ),
      .registers_read_i ( registers_read_i ),
      .flags_o          ( flags_o          )
   );

   typedef struct {
      ucode_cnt_vec_t  idx;
      ucode_offs_vec_t offs;
      logic            accum;
      int              gap;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   last_valid_cyc = 0;
   int   valid_cnt = 0;
   int   done_cnt = 0;
   int   exp_done_lat = 1;
   logic prev_done = 1'b0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every valid pops one expected iteration.
   always @(negedge clk_i) begin
      exp_t e;
      cyc++;
      if (prev_done) check("done_single_cycle", flags_o.done, 1'b0);
      prev_done = flags_o.done;
      if (flags_o.done) begin
         done_cnt++;
         check("done_latency", cyc - last_valid_cyc, exp_done_lat);
      end
      if (flags_o.valid) begin
         valid_cnt++;
         if (sb_q.size() == 0) begin
            check("unexpected_valid", flags_o.valid, 1'b0);
         end else begin
            e = sb_q.pop_front();
            check("idx", flags_o.idx, e.idx);
            check("offs", flags_o.offs, e.offs);
            check("accum", flags_o.accum, e.accum);
            if (e.gap != 0) check("valid_gap", cyc - last_valid_cyc, e.gap);
         end
         last_valid_cyc = cyc;
      end
   end

   task automatic push(input int i0, input int i1, input int o0, input int o1, input logic acc, input int gap);
      exp_t e;
      e.idx     = '0;
      e.idx[0]  = UCODE_CNT_WIDTH'(i0);
      e.idx[1]  = UCODE_CNT_WIDTH'(i1);
      e.offs    = '0;
      e.offs[0] = 32'(o0);
      e.offs[1] = 32'(o1);
      e.accum   = acc;
      e.gap     = gap;
      sb_q.push_back(e);
   endtask

   task automatic push_scn1(input logic acc_on, input logic chk_gap);
      int o0[6]  = '{0, 4, 8, 100, 104, 108};
      int o1[6]  = '{0, 0, 0, 8, 8, 8};
      int i0[6]  = '{0, 1, 2, 0, 1, 2};
      int i1[6]  = '{0, 0, 0, 1, 1, 1};
      int gp[6]  = '{0, 3, 3, 4, 3, 3};
      for (int k = 0; k < 6; k++)
         push(i0[k], i1[k], o0[k], o1[k], acc_on & (i0[k] != 0), chk_gap ? gp[k] : 0);
   endtask

   task automatic program_base();
      ucode_i             = '0;
      registers_read_i    = '0;
      registers_read_i[0] = 32'd4;
      registers_read_i[1] = 32'd100;
      registers_read_i[2] = 32'd8;
   endtask

   task automatic program_scn1();
      program_base();
      ucode_i.code[0]  = '{op_sel: UCODE_OP_ADD, a: 5'd0, b: 5'd4};
      ucode_i.code[1]  = '{op_sel: UCODE_OP_MOV, a: 5'd0, b: 5'd5};
      ucode_i.code[2]  = '{op_sel: UCODE_OP_ADD, a: 5'd1, b: 5'd6};
      ucode_i.loops[0] = '{ucode_addr: 5'd0, nb_ops: 5'd1};
      ucode_i.loops[1] = '{ucode_addr: 5'd1, nb_ops: 5'd2};
      for (int i = 0; i < UCODE_NB_LOOPS; i++) ucode_i.range[i] = 12'd1;
      ucode_i.range[0] = 12'd3;
      ucode_i.range[1] = 12'd2;
   endtask

   task automatic restart(input logic [UCODE_ACC_WIDTH-1:0] acc);
      @(negedge clk_i);
      ctrl_i = '{enable: 1'b0, clear: 1'b1, accum_loop: acc};
      @(negedge clk_i);
      ctrl_i.clear = 1'b0;
      sb_q.delete();
      check("clear_valid", flags_o.valid, 1'b0);
      check("clear_done", flags_o.done, 1'b0);
      check("clear_idx", flags_o.idx, '0);
      check("clear_offs", flags_o.offs, '0);
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      @(negedge clk_i);
      while (!flags_o.valid && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      if (!flags_o.valid) check(tag, flags_o.valid, 1'b1);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      @(negedge clk_i);
      while (!flags_o.done && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      if (!flags_o.done) check(tag, flags_o.done, 1'b1);
      #1;
      check({tag, "_sb_drained"}, sb_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int vc;
      int dc;
      rst_ni = 1'b0;
      ctrl_i = '0;
      program_scn1();
      repeat (3) @(negedge clk_i);
      check("rst_valid", flags_o.valid, 1'b0);
      check("rst_done", flags_o.done, 1'b0);
      check("rst_accum", flags_o.accum, 1'b0);
      check("rst_idx", flags_o.idx, '0);
      check("rst_offs", flags_o.offs, '0);
      rst_ni = 1'b1;

      // Nominal two-level nest, enable held.
      restart(3'd0);
      push_scn1(1'b0, 1'b1);
      exp_done_lat = 1;
      ctrl_i.enable = 1'b1;
      wait_done("scn1_done", 100);

      // Accumulation flag on the innermost loop.
      restart(3'd1);
      push_scn1(1'b1, 1'b1);
      ctrl_i.enable = 1'b1;
      wait_done("accum_done", 100);

      // Degenerate nest: a single iteration, then FINISHED ignores enable.
      program_scn1();
      ucode_i.range[0] = 12'd0;
      ucode_i.range[1] = 12'd1;
      ucode_i.range[2] = 12'd0;
      restart(3'd6);
      push(0, 0, 0, 0, 1'b0, 0);
      ctrl_i.enable = 1'b1;
      wait_done("single_done", 20);
      vc = valid_cnt;
      dc = done_cnt;
      repeat (10) @(negedge clk_i);
      #1;
      check("no_valid_after_done", valid_cnt, vc);
      check("no_done_after_done", done_cnt, dc);

      // Stalls in PRESENT and in EXEC must not alter the sequence.
      program_scn1();
      restart(3'd0);
      push_scn1(1'b0, 1'b0);
      exp_done_lat = 3;
      ctrl_i.enable = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_valid($sformatf("stall_valid%0d", k), 40);
         ctrl_i.enable = 1'b0;
         repeat (2) @(negedge clk_i);
         ctrl_i.enable = 1'b1;
         if (k < 5) begin
            repeat (2) @(negedge clk_i);
            ctrl_i.enable = 1'b0;
            repeat (2) @(negedge clk_i);
            ctrl_i.enable = 1'b1;
         end
      end
      wait_done("stall_done", 20);

      // Clear in the middle of EXEC, then a full restart.
      restart(3'd0);
      push_scn1(1'b0, 1'b1);
      exp_done_lat = 1;
      ctrl_i.enable = 1'b1;
      wait_valid("midclr_first", 20);
      repeat (2) @(negedge clk_i);
      ctrl_i.clear = 1'b1;
      @(negedge clk_i);
      ctrl_i.clear = 1'b0;
      sb_q.delete();
      check("midclr_valid", flags_o.valid, 1'b0);
      check("midclr_offs", flags_o.offs, '0);
      check("midclr_idx", flags_o.idx, '0);
      push_scn1(1'b0, 1'b1);
      wait_done("midclr_done", 100);

      // Read-only destination and out-of-range pointer leave offsets untouched.
      program_base();
      ucode_i.code[0]  = '{op_sel: UCODE_OP_ADD, a: 5'd0, b: 5'd4};
      ucode_i.code[15] = '{op_sel: UCODE_OP_ADD, a: 5'd5, b: 5'd4};
      ucode_i.loops[0] = '{ucode_addr: 5'd15, nb_ops: 5'd2};
      for (int i = 0; i < UCODE_NB_LOOPS; i++) ucode_i.range[i] = 12'd1;
      ucode_i.range[0] = 12'd3;
      restart(3'd0);
      push(0, 0, 0, 0, 1'b0, 0);
      push(1, 0, 0, 0, 1'b0, 4);
      push(2, 0, 0, 0, 1'b0, 4);
      ctrl_i.enable = 1'b1;
      wait_done("noop_done", 40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
